// File: rtl/step_segment_queue.sv
// Per-axis FIFO of step segments that issues them back-to-back to one clk_gen.
// Optional position accumulator enabled by defining STEP_POS_EN.
module step_segment_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_reduction,
    input  logic [30:0]       wr_count,
    input  logic              wr_dir,
    input  logic              flush,
    output logic              gen_run,
    output logic [31:0]       gen_reduction,
    output logic [30:0]       gen_count,
    input  logic              gen_finish,
    output logic              dir_out,
    output logic              busy,
    output logic [ADDR_W:0]   level,
`ifdef STEP_POS_EN
    input  logic              pos_load,
    input  logic [31:0]       pos_value,
    output logic signed [31:0] pos,
`endif
    output logic [31:0]       seg_done
);

    typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [63:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic [31:0]         red_q, red_d;
    logic [30:0]         cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [31:0]         done_q, done_d;
    logic [63:0]         head;
    logic                push, pop, seg_end;

    assign wr_ready = (level_q != FULL);
    assign push     = wr_valid & wr_ready & ~flush;
    assign head     = mem_q[rptr_q];

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        seg_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0 && !flush) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = ACTIVE;
            ACTIVE: begin
                if (gen_finish) begin
                    seg_end = 1'b1;
                    if (level_q != '0 && !flush) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q + ADDR_W'(push);
        rptr_d  = rptr_q + ADDR_W'(pop);
        level_d = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        if (flush) begin
            rptr_d  = wptr_q;
            level_d = '0;
        end
        red_d  = red_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        if (pop) begin
            // clk_gen cannot count down from a zero half-period
            red_d = (head[31:0] == '0) ? 32'd1 : head[31:0];
            cnt_d = head[62:32];
            dir_d = head[63];
        end
        done_d = done_q + 32'(seg_end);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {wr_dir, wr_count, wr_reduction};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            red_q   <= 32'd1;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            red_q   <= red_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

`ifdef STEP_POS_EN
    logic signed [31:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (pos_load) begin
            pos_d = pos_value;
        end else if (seg_end) begin
            pos_d = dir_q ? pos_q + {1'b0, cnt_q} : pos_q - {1'b0, cnt_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`endif

    // run must fall in the same cycle finish rises so clk_gen does not reload
    assign gen_run       = (state_q == START) | ((state_q == ACTIVE) & ~gen_finish);
    assign gen_reduction = red_q;
    assign gen_count     = cnt_q;
    assign dir_out       = dir_q;
    assign busy          = (state_q != IDLE);
    assign level         = level_q;
    assign seg_done      = done_q;

endmodule

// File: tb/tb_step_segment_queue.sv
// Directed bench for step_segment_queue with an ideal clk_gen model attached.
// Define STEP_POS_EN to also exercise the position accumulator.
module tb_step_segment_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_reduction = '0;
    logic [30:0] wr_count = '0;
    logic        wr_dir = 1'b0;
    logic        flush = 1'b0;
    logic        gen_run;
    logic [31:0] gen_reduction;
    logic [30:0] gen_count;
    logic        gen_finish;
    logic        dir_out;
    logic        busy;
    logic [4:0]  level;
    logic [31:0] seg_done;
`ifdef STEP_POS_EN
    logic        pos_load = 1'b0;
    logic [31:0] pos_value = '0;
    logic signed [31:0] pos;
`endif

    always #5 clk = ~clk;

    step_segment_queue dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_reduction(wr_reduction), .wr_count(wr_count), .wr_dir(wr_dir),
        .flush(flush),
        .gen_run(gen_run), .gen_reduction(gen_reduction), .gen_count(gen_count),
        .gen_finish(gen_finish), .dir_out(dir_out), .busy(busy),
        .level(level),
`ifdef STEP_POS_EN
        .pos_load(pos_load), .pos_value(pos_value), .pos(pos),
`endif
        .seg_done(seg_done)
    );

    // ideal clk_gen: loads on run while finished, toggles step every half-period
    logic        m_fin, m_step, m_dwell;
    logic [31:0] m_hc, m_red, m_rem;
    logic        man = 1'b0;
    logic        man_fin = 1'b1;

    assign gen_finish = man ? man_fin : m_fin;

    always @(posedge clk) begin
        if (reset) begin
            m_fin <= 1'b1; m_step <= 1'b0; m_dwell <= 1'b0;
            m_hc <= '0; m_red <= '0; m_rem <= '0;
        end else if (m_fin) begin
            if (gen_run) begin
                m_red   <= gen_reduction;
                m_hc    <= gen_reduction;
                m_dwell <= (gen_count == '0);
                m_rem   <= (gen_count == '0) ? 32'd1 : {gen_count, 1'b0};
                m_fin   <= 1'b0;
            end
        end else if (m_hc == 32'd1) begin
            m_hc <= m_red;
            if (!m_dwell) m_step <= ~m_step;
            if (m_rem == 32'd1) m_fin <= 1'b1;
            m_rem <= m_rem - 32'd1;
        end else begin
            m_hc <= m_hc - 32'd1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses, period, hi_w, last_rise, gap, falls, starts;
    logic step_prev, fin_prev;
    logic [7:0] dirs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        pulses = 0; period = -1; hi_w = -1; last_rise = -1;
        gap = 0; falls = 0; starts = 0; dirs = '0;
        step_prev = m_step; fin_prev = gen_finish;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m_step && !step_prev) begin
            pulses++;
            if (last_rise >= 0) period = cyc - last_rise;
            last_rise = cyc;
        end
        if (!m_step && step_prev) hi_w = cyc - last_rise;
        step_prev = m_step;
        if (gen_finish && falls == 1) gap++;
        if (fin_prev && !gen_finish) falls++;
        fin_prev = gen_finish;
        if (busy && gen_run && gen_finish) begin
            starts++;
            dirs = {dirs[6:0], dir_out};
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [30:0] c, input logic d);
        wr_valid = 1'b1; wr_reduction = r; wr_count = c; wr_dir = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_stats();
    endtask

    task automatic run_idle(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (!busy && level == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gen_run", 64'(gen_run), 64'd0);
        chk("rst_gen_red", 64'(gen_reduction), 64'd1);
        chk("rst_gen_cnt", 64'(gen_count), 64'd0);
        chk("rst_dir", 64'(dir_out), 64'd0);
        chk("rst_seg_done", 64'(seg_done), 64'd0);

        // single segment
        push(32'd4, 31'd3, 1'b1);
        chk("t1_level_after_wr", 64'(level), 64'd1);
        chk("t1_idle_after_wr", 64'(busy), 64'd0);
        tick();
        chk("t1_start_busy", 64'(busy), 64'd1);
        chk("t1_start_run", 64'(gen_run), 64'd1);
        chk("t1_gen_red", 64'(gen_reduction), 64'd4);
        chk("t1_gen_cnt", 64'(gen_count), 64'd3);
        chk("t1_dir", 64'(dir_out), 64'd1);
        chk("t1_level_pop", 64'(level), 64'd0);
        run_idle("t1_timeout", 200);
        chk("t1_pulses", 64'(pulses), 64'd3);
        chk("t1_period", 64'(period), 64'd8);
        chk("t1_hi_w", 64'(hi_w), 64'd4);
        chk("t1_seg_done", 64'(seg_done), 64'd1);
        chk("t1_run_off", 64'(gen_run), 64'd0);

        // back-to-back
        do_reset();
        push(32'd2, 31'd2, 1'b0);
        push(32'd5, 31'd1, 1'b1);
        run_idle("t2_timeout", 200);
        chk("t2_gap", 64'(gap), 64'd2);
        chk("t2_starts", 64'(starts), 64'd2);
        chk("t2_dirs", 64'(dirs[1:0]), 64'd1);
        chk("t2_pulses", 64'(pulses), 64'd3);
        chk("t2_seg_done", 64'(seg_done), 64'd2);

        // zero reduction clamp
        do_reset();
        push(32'd0, 31'd1, 1'b0);
        tick();
        chk("t5_gen_red", 64'(gen_reduction), 64'd1);
        run_idle("t5_timeout", 100);
        chk("t5_pulses", 64'(pulses), 64'd1);
        chk("t5_hi_w", 64'(hi_w), 64'd1);

        // flush during segment 1
        do_reset();
        push(32'd3, 31'd2, 1'b1);
        push(32'd2, 31'd4, 1'b0);
        push(32'd2, 31'd4, 1'b0);
        chk("t4_level_q", 64'(level), 64'd2);
        tick(); tick();
        flush = 1'b1;
        wr_valid = 1'b1; wr_reduction = 32'd9; wr_count = 31'd9;
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        chk("t4_level_flush", 64'(level), 64'd0);
        chk("t4_busy_flush", 64'(busy), 64'd1);
        run_idle("t4_timeout", 200);
        chk("t4_pulses", 64'(pulses), 64'd2);
        chk("t4_starts", 64'(starts), 64'd1);
        chk("t4_seg_done", 64'(seg_done), 64'd1);

        // fill to full while clk_gen held busy
        do_reset();
        man = 1'b1; man_fin = 1'b1;
        push(32'd9, 31'd1, 1'b0);
        tick();
        man_fin = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) push(32'd100 + 32'(i), 31'd1, 1'b0);
        chk("t3_level_full", 64'(level), 64'd16);
        chk("t3_wr_ready", 64'(wr_ready), 64'd0);
        push(32'd999, 31'd1, 1'b0);
        chk("t3_level_drop", 64'(level), 64'd16);
        man_fin = 1'b1;
        tick();
        chk("t3_fifo_order", 64'(gen_reduction), 64'd100);
        chk("t3_level_pop", 64'(level), 64'd15);
        chk("t3_seg_done", 64'(seg_done), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t3_idle", 64'(busy), 64'd0);
        chk("t3_seg_done2", 64'(seg_done), 64'd2);

        // reset mid-ACTIVE
        push(32'd7, 31'd5, 1'b1);
        tick();
        man_fin = 1'b0;
        tick();
        push(32'd7, 31'd5, 1'b1);
        chk("t6_pre_level", 64'(level), 64'd1);
        chk("t6_pre_run", 64'(gen_run), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_run", 64'(gen_run), 64'd0);
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_seg_done", 64'(seg_done), 64'd0);
        chk("t6_dir", 64'(dir_out), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        man = 1'b0; man_fin = 1'b1;

`ifdef STEP_POS_EN
        do_reset();
        chk("p_rst", 64'(pos), 64'd0);
        push(32'd2, 31'd3, 1'b1);
        push(32'd2, 31'd1, 1'b0);
        run_idle("p_timeout", 200);
        chk("p_pos", 64'(pos), 64'd2);
        pos_load = 1'b1; pos_value = 32'd100;
        tick();
        pos_load = 1'b0;
        chk("p_load", 64'(pos), 64'd100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
